// File: rtl/sprite_animator.sv
// Sprite draw engine with a self-running animation sequencer.
// Maps the VGA scan position to a sprite-sheet address and advances the frame index.
module sprite_animator #(
  parameter int unsigned SPR_W       = 10,
  parameter int unsigned SPR_H       = 10,
  parameter int unsigned N_FRAMES    = 8,
  parameter int unsigned SHEET_W     = 360,
  parameter int unsigned SHEET_DEPTH = 86400,
  parameter int unsigned ROW_BASE    = 10,
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [8:0]        pos_x,
  input  logic [8:0]        pos_y,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              flip_h,
  input  logic              restart,
  output logic [3:0]        frame,
  output logic              done,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              is_object
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CALC_W = ADDR_W + 2;
  localparam logic [3:0]        LAST_FRAME = 4'(N_FRAMES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_PING = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        frame_q, frame_d;
  dir_e              dir_q, dir_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              is_object_q, is_object_d;
  logic              tick_run_c, term_c;

  logic [9:0]        x_c, y_c, px_c, py_c, col_raw_c, col_c, dy_c;
  logic              hit_c;
  logic [CALC_W-1:0] row_c, sum_c, addr_c;
  logic              unused_c;

  // Sequencer next state: restart beats a terminal tick; hold freezes everything.
  always_comb begin
    tick_d     = tick_q;
    frame_d    = frame_q;
    dir_d      = dir_q;
    done_d     = done_q;
    tick_run_c = enable && (mode != MODE_HOLD);
    term_c     = tick_run_c && (tick_q == TICK_LAST);
    if (restart) begin
      tick_d  = '0;
      frame_d = '0;
      dir_d   = DIR_UP;
      done_d  = 1'b0;
    end else if (tick_run_c) begin
      tick_d = term_c ? '0 : tick_q + 1'b1;
      if (term_c) begin
        case (mode)
          MODE_LOOP: frame_d = (frame_q >= LAST_FRAME) ? 4'd0 : frame_q + 4'd1;
          MODE_PING: begin
            if (N_FRAMES == 1) begin
              frame_d = 4'd0;
            end else if (dir_q == DIR_UP) begin
              if (frame_q >= LAST_FRAME) begin
                frame_d = frame_q - 4'd1;
                dir_d   = DIR_DOWN;
              end else begin
                frame_d = frame_q + 4'd1;
              end
            end else begin
              if (frame_q == 4'd0) begin
                frame_d = 4'd1;
                dir_d   = DIR_UP;
              end else begin
                frame_d = frame_q - 4'd1;
              end
            end
          end
          MODE_ONCE: begin
            if (frame_q < LAST_FRAME) begin
              frame_d = frame_q + 4'd1;
              done_d  = done_q | ((frame_q + 4'd1) == LAST_FRAME);
            end else begin
              done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Draw path: 10-bit compares keep sprites near the right/bottom edge from wrapping.
  always_comb begin
    x_c       = {1'b0, h_cnt[9:1]};
    y_c       = {1'b0, v_cnt[9:1]};
    px_c      = {1'b0, pos_x};
    py_c      = {1'b0, pos_y};
    hit_c     = (x_c >= px_c) && (x_c < px_c + 10'(SPR_W)) &&
                (y_c >= py_c) && (y_c < py_c + 10'(SPR_H));
    col_raw_c = x_c - px_c;
    col_c     = flip_h ? 10'(SPR_W - 1) - col_raw_c : col_raw_c;
    dy_c      = y_c - py_c;
    row_c     = CALC_W'(dy_c) + CALC_W'(ROW_BASE);
    sum_c     = CALC_W'(col_c) + CALC_W'(SPR_W) * CALC_W'(frame_q) +
                row_c * CALC_W'(SHEET_W);
    addr_c    = (sum_c >= CALC_W'(SHEET_DEPTH)) ? sum_c - CALC_W'(SHEET_DEPTH) : sum_c;
    pixel_addr_d = hit_c ? ADDR_W'(addr_c) : '0;
    is_object_d  = hit_c;
  end

  assign unused_c = ^{h_cnt[0], v_cnt[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= '0;
      frame_q      <= '0;
      dir_q        <= DIR_UP;
      done_q       <= 1'b0;
      pixel_addr_q <= '0;
      is_object_q  <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      frame_q      <= frame_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      pixel_addr_q <= pixel_addr_d;
      is_object_q  <= is_object_d;
    end
  end

  assign frame      = frame_q;
  assign done       = done_q;
  assign pixel_addr = pixel_addr_q;
  assign is_object  = is_object_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: three instances (main, ping-pong, sheet-wrap)
// with expected values queued at drive time and popped when outputs are sampled.
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  h_cnt, v_cnt;
  logic [8:0]  pos_x, pos_y;
  logic        enable, enable_p;
  logic [1:0]  mode, mode_p;
  logic        flip_h, restart, restart_p;

  logic [3:0]  frame_a, frame_p, frame_w;
  logic        done_a, done_p, done_w;
  logic [16:0] addr_a, addr_p, addr_w;
  logic        obj_a, obj_p, obj_w;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  int unsigned hh, xx;
  logic [31:0] ea;
  int          pp [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 3, 0};

  always #5 clk = ~clk;

  sprite_animator #(.N_FRAMES(8), .TICK_DIV(4)) u_a (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable), .mode(mode), .flip_h(flip_h), .restart(restart),
    .frame(frame_a), .done(done_a), .pixel_addr(addr_a), .is_object(obj_a));

  sprite_animator #(.N_FRAMES(4), .TICK_DIV(1)) u_p (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable_p), .mode(mode_p), .flip_h(flip_h), .restart(restart_p),
    .frame(frame_p), .done(done_p), .pixel_addr(addr_p), .is_object(obj_p));

  sprite_animator #(.N_FRAMES(8), .TICK_DIV(4), .ROW_BASE(238)) u_w (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .pos_x(pos_x), .pos_y(pos_y),
    .enable(enable), .mode(mode), .flip_h(flip_h), .restart(restart),
    .frame(frame_w), .done(done_w), .pixel_addr(addr_w), .is_object(obj_w));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  task automatic draw(input int h, input int v, input int px, input int py, input logic f);
    h_cnt  = 10'(h);
    v_cnt  = 10'(v);
    pos_x  = 9'(px);
    pos_y  = 9'(py);
    flip_h = f;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; enable_p = 1'b0; mode = 2'b00; mode_p = 2'b01;
    restart = 1'b0; restart_p = 1'b0;
    draw(0, 0, 300, 300, 1'b0);
    step(2);
    push("rst_frame", 0);   pop_chk(32'(frame_a));
    push("rst_done", 0);    pop_chk(32'(done_a));
    push("rst_addr", 0);    pop_chk(32'(addr_a));
    push("rst_obj", 0);     pop_chk(32'(obj_a));
    push("rst_frame_p", 0); pop_chk(32'(frame_p));
    push("rst_done_p", 0);  pop_chk(32'(done_p));
    push("rst_addr_p", 0);  pop_chk(32'(addr_p));
    push("rst_obj_p", 0);   pop_chk(32'(obj_p));
    push("rst_done_w", 0);  pop_chk(32'(done_w));
    rst = 1'b0;

    // Ping-pong N=4, one step per cycle; switch to loop while descending at frame 2.
    enable_p = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) mode_p = 2'b00;
      push($sformatf("pingpong_%0d", i), 32'(pp[i]));
      step(1);
      pop_chk(32'(frame_p));
    end
    enable_p = 1'b0;

    // Loop mode, TICK_DIV=4.
    enable = 1'b1; mode = 2'b00;
    push("loop_first_step", 1);  step(4);  pop_chk(32'(frame_a));
    push("loop_wrap", 0);        step(28); pop_chk(32'(frame_a));
    push("loop_pre_pause", 1);   step(6);  pop_chk(32'(frame_a));
    enable = 1'b0;
    push("pause_frozen", 1);     step(10); pop_chk(32'(frame_a));
    enable = 1'b1;
    push("resume_tick2to3", 1);  step(1);  pop_chk(32'(frame_a));
    push("resume_term", 2);      step(1);  pop_chk(32'(frame_a));
    push("loop_frame3", 3);      step(4);  pop_chk(32'(frame_a));
    mode = 2'b11;
    push("hold_frame", 3);       step(3);  pop_chk(32'(frame_a));
    push("hold_frame_w", 3);     pop_chk(32'(frame_w));

    // Address generation at frame 3.
    draw(204, 104, 100, 50, 1'b0);
    push("addr_hit", 4352); push("obj_hit", 1);
    step(1); pop_chk(32'(addr_a)); pop_chk(32'(obj_a));
    draw(204, 104, 100, 50, 1'b1);
    push("addr_flip", 4357); push("obj_flip", 1);
    step(1); pop_chk(32'(addr_a)); pop_chk(32'(obj_a));
    draw(220, 104, 100, 50, 1'b0);
    push("addr_miss", 0); push("obj_miss", 0);
    step(1); pop_chk(32'(addr_a)); pop_chk(32'(obj_a));
    draw(204, 118, 100, 50, 1'b0);
    push("addr_lastrow", 6872); push("addr_wrap_w", 2552); push("obj_wrap_w", 1);
    step(1); pop_chk(32'(addr_a)); pop_chk(32'(addr_w)); pop_chk(32'(obj_w));

    // Right-edge sweep: x=502..511 then x=0..3 with pos_x=505.
    for (int k = 0; k < 28; k++) begin
      hh = (1004 + k) % 1024;
      xx = hh >> 1;
      draw(int'(hh), 104, 505, 50, 1'b0);
      ea = (xx >= 505) ? 32'((xx - 505) + 30 + 12 * 360) : 32'd0;
      push($sformatf("edge_obj_h%0d", hh), (xx >= 505) ? 32'd1 : 32'd0);
      push($sformatf("edge_addr_h%0d", hh), ea);
      step(1);
      pop_chk(32'(obj_a));
      pop_chk(32'(addr_a));
    end

    // One-shot.
    draw(0, 0, 300, 300, 1'b0);
    mode = 2'b10; restart = 1'b1;
    push("os_restart_frame", 0); push("os_restart_done", 0);
    step(1); restart = 1'b0;
    pop_chk(32'(frame_a)); pop_chk(32'(done_a));
    push("os_frame6", 6); push("os_done_early", 0);
    step(27); pop_chk(32'(frame_a)); pop_chk(32'(done_a));
    push("os_frame7", 7); push("os_done_set", 1);
    step(1); pop_chk(32'(frame_a)); pop_chk(32'(done_a));
    push("os_hold_frame", 7); push("os_hold_done", 1);
    step(8); pop_chk(32'(frame_a)); pop_chk(32'(done_a));
    mode = 2'b00;
    push("os_modechg_frame", 0); push("os_done_sticky", 1);
    step(4); pop_chk(32'(frame_a)); pop_chk(32'(done_a));
    restart = 1'b1;
    push("restart_frame", 0); push("restart_done", 0);
    step(1); restart = 1'b0;
    pop_chk(32'(frame_a)); pop_chk(32'(done_a));

    // Restart coincident with a terminal tick.
    push("coll_pre", 1);        step(7); pop_chk(32'(frame_a));
    restart = 1'b1;
    push("coll_restart", 0);    step(1); pop_chk(32'(frame_a));
    restart = 1'b0;
    push("coll_tick_zero", 0);  step(3); pop_chk(32'(frame_a));
    push("coll_next_step", 1);  step(1); pop_chk(32'(frame_a));

    // Reset mid-animation with done set and the sprite hit.
    mode = 2'b10;
    push("pre_rst_done", 1); push("pre_rst_frame", 7);
    step(30); pop_chk(32'(done_a)); pop_chk(32'(frame_a));
    draw(204, 104, 100, 50, 1'b0);
    push("pre_rst_obj", 1); push("pre_rst_addr", 4392);
    step(1); pop_chk(32'(obj_a)); pop_chk(32'(addr_a));
    rst = 1'b1;
    push("mid_rst_frame", 0); push("mid_rst_done", 0);
    push("mid_rst_addr", 0);  push("mid_rst_obj", 0);
    step(1);
    pop_chk(32'(frame_a)); pop_chk(32'(done_a)); pop_chk(32'(addr_a)); pop_chk(32'(obj_a));
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
